// File: rtl/mult_div_unit_if.sv
// Handshake and operand/result bundle between the control unit and the
// iterative multiply/divide unit.
interface mult_div_unit_if;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and restoring divide
// producing the HI/LO pair; one iteration per clock.
module mult_div_unit (
    input  logic           i_clk,
    input  logic           i_reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic [32:0] r_acc;       // Booth accumulator, or remainder during divide
    logic [31:0] r_q;         // multiplier, or dividend/quotient shift register
    logic        r_qm1;
    logic [31:0] r_m;         // multiplicand, or divisor magnitude
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_div_zero;

    logic        w_accept;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_m_ext;
    logic [32:0] w_booth_sum;
    logic [32:0] w_booth_acc;
    logic [31:0] w_booth_q;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_fits;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;

    assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_abs_a  = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
    assign w_abs_b  = bus.b[31] ? (~bus.b + 32'd1) : bus.b;

    // 33-bit accumulator keeps a = 0x80000000 from overflowing on subtract
    assign w_m_ext = {r_m[31], r_m};
    always_comb begin
        w_booth_sum = r_acc;
        case ({r_q[0], r_qm1})
            2'b01:   w_booth_sum = r_acc + w_m_ext;
            2'b10:   w_booth_sum = r_acc - w_m_ext;
            default: w_booth_sum = r_acc;
        endcase
    end
    assign w_booth_acc = {w_booth_sum[32], w_booth_sum[32:1]};
    assign w_booth_q   = {w_booth_sum[0], r_q[31:1]};

    assign w_rem_sh   = {r_acc[31:0], r_q[31]};
    assign w_diff     = w_rem_sh - {1'b0, r_m};
    assign w_fits     = ~w_diff[32];
    assign w_rem_next = w_fits ? w_diff[31:0] : w_rem_sh[31:0];
    assign w_quo_next = {r_q[30:0], w_fits};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 6'd0;
            r_acc      <= 33'd0;
            r_q        <= 32'd0;
            r_qm1      <= 1'b0;
            r_m        <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_cnt <= 6'd32;
                        r_acc <= 33'd0;
                        r_qm1 <= 1'b0;
                        if (!bus.op) begin
                            r_q     <= bus.b;
                            r_m     <= bus.a;
                            r_busy  <= 1'b1;
                            r_state <= S_MULT;
                        end else if (bus.b == 32'd0) begin
                            // hi/lo deliberately untouched on divide by zero
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_q     <= w_abs_a;
                            r_m     <= w_abs_b;
                            r_neg_q <= bus.a[31] ^ bus.b[31];
                            r_neg_r <= bus.a[31];
                            r_busy  <= 1'b1;
                            r_state <= S_DIV;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_MULT: begin
                    r_acc <= w_booth_acc;
                    r_q   <= w_booth_q;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_hi    <= w_booth_acc[31:0];
                        r_lo    <= w_booth_q;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_acc <= {1'b0, w_rem_next};
                    r_q   <= w_quo_next;
                    r_cnt <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_lo    <= r_neg_q ? (~r_q + 32'd1) : r_q;
                    r_hi    <= r_neg_r ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative signed multiply/divide unit for the multicycle CPU datapath. It consumes the A and B register outputs and produces the HI/LO pair used by mfhi/mflo. Operations are started by the control unit, which stalls in a wait state until `done`. Multiply uses radix-2 Booth; divide is restoring division on magnitudes with MIPS sign rules.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  in  1  request pulse; sampled only when the FSM is in IDLE or DONE.
- op  in  1  0 = mult, 1 = div; sampled together with start.
- a  in  32  multiplicand or dividend (signed), taken from A_Out.
- b  in  32  multiplier or divisor (signed), taken from B_Out.
- hi  out  32  mult: product[63:32]; div: remainder.
- lo  out  32  mult: product[31:0]; div: quotient.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  one-cycle pulse with done when a div had b == 0.

## Operation
- FSM states: IDLE, MULT, DIV, FIX, DONE.
- In IDLE or DONE, start=1 latches a and b, loads counter = 32, and takes one of three paths:
  - op=0: go to MULT.
  - op=1 with b != 0: go to DIV.
  - op=1 with b == 0: go straight to DONE with div_zero set.
- MULT (Booth):
  - State is a 65-bit {acc[31:0], q[31:0], q_-1}, loaded with {0, b, 0}.
  - Each cycle: on pair {q0, q_-1} = 01, acc += a; on 10, acc -= a. Then arithmetic-shift the whole 65 bits right by 1. Counter decrements.
  - When the counter reaches 0, write hi = acc and lo = q, then go to DONE.
  - The result is the exact signed 64-bit product, including a = 0x80000000 (acc must be 33 bits internally, or an equivalent overflow-safe form).
- DIV (restoring):
  - Operate on |a| and |b| as 32-bit unsigned values; |0x80000000| = 0x80000000.
  - Each cycle: shift {rem, quo} left by 1, try rem − |b|; if non-negative, keep the difference and set quo[0] = 1.
  - After 32 iterations go to FIX.
- FIX, one cycle:
  - lo = quo, negated if sign(a) != sign(b).
  - hi = rem, negated if a < 0.
  - Go to DONE.
  - Result: quotient truncates toward zero; remainder takes the sign of the dividend.
- Overflow case: 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0. No flag is raised.
- Divide by zero: hi and lo keep their previous values; done = div_zero = 1 for one cycle.
- DONE lasts exactly one cycle, then IDLE unless start is accepted in that cycle (back-to-back operation).
- start while busy is ignored. a and b may change freely after the start edge.
- hi and lo change only on the completion edge and otherwise hold their values.

## Timing
- Reset (reset=0, asynchronous): state = IDLE, hi = lo = 0, busy = done = div_zero = 0, counter = 0. Reset mid-operation aborts it with no partial result.
- Let E0 be the edge that samples start.
- busy is high in the cycle after E0 and stays high until the edge that enters DONE. busy is low in DONE.
- Latency:
  - mult: hi/lo update at E32; done is high in the cycle E32→E33.
  - div: iterations E1..E32, FIX at E33; done is high in the cycle E33→E34.
  - div by zero: done and div_zero are high in the cycle E0→E1; busy never rises.
- done and div_zero are registered outputs, never combinational from start.

## Test plan
- Mult: a=7, b=−3 → after 32 edges, hi=0xFFFFFFFF, lo=0xFFFFFFEB; done is high for exactly one cycle.
- Mult extreme: a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0x00000000. Also a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0, lo=1.
- Div signs: (−7, 2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. (7, −2) → lo=0xFFFFFFFD, hi=1. (0x80000000, 0xFFFFFFFF) → lo=0x80000000, hi=0. Each with done at 33 edges after E0.
- Div by zero: preload hi=0x11, lo=0x22 via a prior op, then div with b=0 → the next cycle has done=div_zero=1, busy=0, and hi/lo unchanged.
- Handshake: assert start mid-mult → ignored, result unchanged. Assert start during the DONE cycle → the new op is accepted with busy high the next cycle.
- Reset: drop reset low at iteration 15 of a div → outputs clear immediately; after release, start a mult 5×6 → hi=0, lo=30.
